// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int BUF_DEPTH      = 3;
    localparam int PTR_W          = 2;
    localparam int OCC_W          = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rd_state_e;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [OCC_W-1:0] occ_t;

    // Circular increment over the BUF_DEPTH buffer slots.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Three-entry circular buffer that absorbs the FIFO's read latency.
// The caller guarantees push never happens when full (credit logic upstream).
module fifo_rd_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr;
    logic                  do_pop;

    assign do_pop = pop && (occ != '0);
    assign head   = mem[rd_ptr];

    // Pointer and occupancy tracking; simultaneous push+pop leaves occ unchanged.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   occ <= occ + occ_t'(1);
                2'b01:   occ <= occ - occ_t'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Word storage, written at the tail on push.
    // NOTE: storage is normally left unreset, but here the head drives m_data
    // directly and must read zero out of reset, so the three slots are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Consumer-side adapter: pulls words from a synchronous FIFO read port and
// presents them on a valid/ready stream at up to one word per cycle.
// Reads are issued only against free buffer credit, so m_ready never
// reaches the FIFO read enable combinationally.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  idle,
    output logic [CNT_W-1:0]      words_out
);

    rd_state_e  state;
    logic       inflight;
    occ_t       occ;
    logic [2:0] credit_used;
    logic       accept;

    // Buffered words plus the one possibly returning from the FIFO this cycle.
    assign credit_used = {1'b0, occ} + {2'b00, inflight};
    assign fifo_r_en   = (state == RUN) && !fifo_empty && (credit_used < 3'(BUF_DEPTH));
    assign m_valid     = (occ != '0);
    assign accept      = m_valid && m_ready;
    assign idle        = (state == IDLE);

    fifo_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (accept),
        .occ       (occ),
        .head      (m_data)
    );

    // Fetch control: RUN fetches, DRAIN lets buffered/in-flight words finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (en) state <= RUN;
                end
                RUN: begin
                    if (!en) state <= DRAIN;
                end
                DRAIN: begin
                    if (en) begin
                        state <= RUN;
                    end else if ((occ == '0) && !inflight) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A read issued this cycle returns valid FIFO data next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_r_en;
        end
    end

    // Delivered-word counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_out <= '0;
        end else if (accept) begin
            words_out <= words_out + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream driving a small behavioural 8-deep FIFO.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_r_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          idle;
    logic [CW-1:0] words_out;

    // Behavioural FIFO (1-cycle registered read data)
    logic          f_rst_n;
    logic          fw_en;
    logic [DW-1:0] fw_data;
    logic [DW-1:0] fmem [8];
    logic [2:0]    fwp;
    logic [2:0]    frp;
    logic [3:0]    fcnt;
    logic [DW-1:0] fdout;
    int            frd_cnt;
    logic          do_rd;
    logic          do_wr;

    int            total = 0;
    int            passed = 0;
    int            underflow_seen = 0;
    int            rd0;
    int            wait_cnt;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .idle       (idle),
        .words_out  (words_out)
    );

    assign fifo_empty = (fcnt == 4'd0);
    assign fifo_data  = fdout;
    assign do_rd      = fifo_r_en && !fifo_empty;
    assign do_wr      = fw_en && (fcnt != 4'd8);

    always @(posedge clk or negedge f_rst_n) begin
        if (!f_rst_n) begin
            fwp     <= '0;
            frp     <= '0;
            fcnt    <= '0;
            fdout   <= '0;
            frd_cnt <= 0;
        end else begin
            if (do_wr) begin
                fmem[fwp] <= fw_data;
                fwp       <= fwp + 3'd1;
            end
            if (do_rd) begin
                fdout   <= fmem[frp];
                frp     <= frp + 3'd1;
                frd_cnt <= frd_cnt + 1;
            end
            fcnt <= fcnt + 4'(do_wr) - 4'(do_rd);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"},   32'(m_valid),   32'd0);
        check({tag, "_r_en"},      32'(fifo_r_en), 32'd0);
        check({tag, "_m_data"},    32'(m_data),    32'd0);
        check({tag, "_idle"},      32'(idle),      32'd1);
        check({tag, "_words_out"}, 32'(words_out), 32'd0);
    endtask

    // Scoreboard: every accepted word must be the oldest expected one.
    always @(negedge clk) begin
        #1;
        if (fifo_r_en && fifo_empty) underflow_seen <= underflow_seen + 1;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) check("stream_extra_word", 32'(exp_q.size()), 32'd1);
            else                   check("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
    end

    // Feed n words into the FIFO under flow control and wait until all are accepted.
    task automatic stream_words(input logic [DW-1:0] base, input int n, input bit rnd);
        int sent = 0;
        int cyc  = 0;
        while ((sent < n || exp_q.size() != 0 || m_valid) && cyc < 3000) begin
            @(negedge clk);
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < n && fcnt < 4'd8) begin
                fw_en   = 1'b1;
                fw_data = 8'(base + 8'(sent));
                exp_q.push_back(8'(base + 8'(sent)));
                sent++;
            end else begin
                fw_en = 1'b0;
            end
            cyc++;
        end
        fw_en = 1'b0;
        check("stream_complete", 32'(cyc < 3000), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; f_rst_n = 1'b0; en = 1'b0; m_ready = 1'b0;
        fw_en = 1'b0; fw_data = '0;
        #2;
        check_reset_outputs("por");
        @(negedge clk); rst_n = 1'b1; f_rst_n = 1'b1;
        @(negedge clk); #2;
        check("post_rst_idle", 32'(idle), 32'd1);

        // 1: five words, latency and back-to-back delivery
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); fw_en = 1'b1; fw_data = 8'(8'h11 + i); exp_q.push_back(8'(8'h11 + i));
        end
        @(negedge clk); fw_en = 1'b0; en = 1'b1; m_ready = 1'b1;
        #2;
        check("t1_r_en_idle", 32'(fifo_r_en), 32'd0);
        @(negedge clk); #2;
        check("t1_first_r_en", 32'(fifo_r_en), 32'd1);
        check("t1_valid_n1",   32'(m_valid),   32'd0);
        @(negedge clk); #2;
        check("t1_valid_n2",   32'(m_valid),   32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            check("t1_valid", 32'(m_valid), 32'd1);
            check("t1_data",  32'(m_data),  32'(8'h11 + i));
        end
        @(negedge clk); #2;
        check("t1_valid_end", 32'(m_valid),    32'd0);
        check("t1_words_out", 32'(words_out),  32'd5);
        check("t1_empty",     32'(fifo_empty), 32'd1);

        // 2: stalled sink, credit limits reads to 3
        rd0 = frd_cnt;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); m_ready = 1'b0; fw_en = 1'b1;
            fw_data = 8'(8'h20 + i); exp_q.push_back(8'(8'h20 + i));
        end
        @(negedge clk); fw_en = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("t2_reads",     32'(frd_cnt - rd0), 32'd3);
        check("t2_fifo_cnt",  32'(fcnt),          32'd5);
        check("t2_hold_data", 32'(m_data),        32'h20);
        check("t2_no_r_en",   32'(fifo_r_en),     32'd0);
        @(negedge clk); #2;
        check("t2_hold_again", 32'(m_data), 32'h20);
        @(negedge clk); m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2;
            check("t2_valid", 32'(m_valid), 32'd1);
            check("t2_data",  32'(m_data),  32'(8'h20 + i));
            @(negedge clk);
        end
        #2;
        check("t2_valid_end", 32'(m_valid),   32'd0);
        check("t2_words_out", 32'(words_out), 32'hD);

        // 3: random backpressure with concurrent writes
        stream_words(8'h00, 64, 1'b1);
        #2;
        check("t3_no_underflow", 32'(underflow_seen), 32'd0);
        check("t3_words_out",    32'(words_out),      32'hD);
        check("t3_fifo_empty",   32'(fcnt),           32'd0);

        // 4: drop en with 2 buffered + 1 in flight
        rd0 = frd_cnt;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); m_ready = 1'b0; fw_en = 1'b1; fw_data = 8'(8'h40 + i);
            if (i < 3) exp_q.push_back(8'(8'h40 + i));
        end
        @(negedge clk); fw_en = 1'b0; en = 1'b0;
        #2;
        check("t4_reads",    32'(frd_cnt - rd0), 32'd3);
        check("t4_fifo_cnt", 32'(fcnt),          32'd1);
        check("t4_head",     32'(m_data),        32'h40);
        @(negedge clk); m_ready = 1'b1;
        #2;
        check("t4_drain_no_r_en", 32'(fifo_r_en), 32'd0);
        check("t4_not_idle",      32'(idle),      32'd0);
        repeat (4) @(negedge clk);
        #2;
        check("t4_idle",       32'(idle),           32'd1);
        check("t4_valid",      32'(m_valid),        32'd0);
        check("t4_words_wrap", 32'(words_out),      32'd0);
        check("t4_untouched",  32'(fcnt),           32'd1);
        check("t4_reads_end",  32'(frd_cnt - rd0),  32'd3);

        // 5: async reset mid-stream
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); m_ready = 1'b0; fw_en = 1'b1; fw_data = 8'(8'h50 + i);
        end
        @(negedge clk); fw_en = 1'b0; en = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        check("t5_pre_valid", 32'(m_valid), 32'd1);
        check("t5_pre_head",  32'(m_data),  32'h43);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        check("t5_fifo_cnt", 32'(fcnt), 32'd3);
        @(negedge clk); rst_n = 1'b1; m_ready = 1'b1;
        exp_q.push_back(8'h52); exp_q.push_back(8'h53); exp_q.push_back(8'h54);
        wait_cnt = 0;
        #2;
        while (!m_valid && wait_cnt < 20) begin
            @(negedge clk); #2; wait_cnt++;
        end
        check("t5_valid_seen", 32'(m_valid), 32'd1);
        check("t5_head",       32'(m_data),  32'h52);
        repeat (6) @(negedge clk);
        #2;
        check("t5_words_out", 32'(words_out),    32'd3);
        check("t5_sb_empty",  32'(exp_q.size()), 32'd0);

        // 6: 4-bit counter wraps 15 -> 0
        @(negedge clk); m_ready = 1'b0;
        #2; rst_n = 1'b0;
        #1;
        check("t6_rst_count", 32'(words_out), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        stream_words(8'h60, 15, 1'b0);
        #2;
        check("t6_count_15", 32'(words_out), 32'hF);
        stream_words(8'h6F, 1, 1'b0);
        #2;
        check("t6_count_wrap", 32'(words_out), 32'd0);
        stream_words(8'h70, 1, 1'b0);
        #2;
        check("t6_count_1",      32'(words_out),      32'd1);
        check("end_no_underflow", 32'(underflow_seen), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
